// File: rtl/layer_compositor.sv
// N-layer VGA pixel compositor: two-stage pixel pipeline with frame-synchronous layer enable commit.
// Optional colour keying of layer pixels is enabled by defining COMPOSITOR_COLORKEY_EN.
module layer_compositor #(
    parameter int              NUM_LAYERS = 4,
    parameter int              CH_W       = 4,
    parameter logic [3*CH_W-1:0] KEY_COLOR = 12'h0F0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_en,
    input  logic                           valid_in,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic [NUM_LAYERS-1:0]          layer_valid,
    input  logic [NUM_LAYERS*3*CH_W-1:0]   layer_pixel,
    input  logic [3*CH_W-1:0]              bg_pixel,
    input  logic [NUM_LAYERS-1:0]          layer_en_req,
    input  logic                           layer_en_wr,
    output logic                           hsync,
    output logic                           vsync,
    output logic [CH_W-1:0]                vgaRed,
    output logic [CH_W-1:0]                vgaGreen,
    output logic [CH_W-1:0]                vgaBlue,
    output logic [NUM_LAYERS-1:0]          layer_en_active,
    output logic [7:0]                     frame_cnt
);

    localparam int PIX_W = 3 * CH_W;

    // Stage 1: registered copy of the pixel inputs
    logic                          s1_valid_reg;
    logic                          s1_hsync_reg;
    logic                          s1_vsync_reg;
    logic [NUM_LAYERS-1:0]         s1_layer_valid_reg;
    logic [NUM_LAYERS*PIX_W-1:0]   s1_layer_pixel_reg;
    logic [PIX_W-1:0]              s1_bg_reg;

    // Stage 2: composed output
    logic [PIX_W-1:0]              rgb_reg;
    logic                          hsync_reg;
    logic                          vsync_reg;

    // Enable mask double buffer and frame tracking
    logic [NUM_LAYERS-1:0]         active_reg;
    logic [NUM_LAYERS-1:0]         pending_reg;
    logic                          pending_flag_reg;
    logic [7:0]                    frame_cnt_reg;
    logic                          vsync_prev_reg;

    logic [NUM_LAYERS-1:0]         eff;
    logic [PIX_W-1:0]              sel_pixel;
    logic [PIX_W-1:0]              rgb_next;
    logic                          boundary;

    // A layer competes only when it asks to draw and is enabled in the committed mask
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
`ifdef COMPOSITOR_COLORKEY_EN
            assign eff[gi] = s1_layer_valid_reg[gi] & active_reg[gi]
                           & (s1_layer_pixel_reg[gi*PIX_W +: PIX_W] != KEY_COLOR);
`else
            assign eff[gi] = s1_layer_valid_reg[gi] & active_reg[gi];
`endif
        end
    endgenerate

    // Ascending scan so the highest effective index overwrites lower ones
    always_comb begin
        sel_pixel = s1_bg_reg;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (eff[i]) begin
                sel_pixel = s1_layer_pixel_reg[i*PIX_W +: PIX_W];
            end
        end
        rgb_next = s1_valid_reg ? sel_pixel : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg       <= 1'b0;
            s1_hsync_reg       <= 1'b1;
            s1_vsync_reg       <= 1'b1;
            s1_layer_valid_reg <= '0;
            s1_layer_pixel_reg <= '0;
            s1_bg_reg          <= '0;
            rgb_reg            <= '0;
            hsync_reg          <= 1'b1;
            vsync_reg          <= 1'b1;
        end else if (pix_en) begin
            s1_valid_reg       <= valid_in;
            s1_hsync_reg       <= hsync_in;
            s1_vsync_reg       <= vsync_in;
            s1_layer_valid_reg <= layer_valid;
            s1_layer_pixel_reg <= layer_pixel;
            s1_bg_reg          <= bg_pixel;
            rgb_reg            <= rgb_next;
            hsync_reg          <= s1_hsync_reg;
            vsync_reg          <= s1_vsync_reg;
        end
    end

    // Frame boundary: vsync_in falling edge as seen on consecutive pixel strobes
    assign boundary = pix_en & vsync_prev_reg & ~vsync_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg       <= '1;
            pending_reg      <= '1;
            pending_flag_reg <= 1'b0;
            frame_cnt_reg    <= 8'd0;
            vsync_prev_reg   <= 1'b1;
        end else begin
            if (pix_en) begin
                vsync_prev_reg <= vsync_in;
            end
            if (boundary) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
                // A write landing on the boundary edge bypasses the pending register
                if (layer_en_wr) begin
                    active_reg       <= layer_en_req;
                    pending_reg      <= layer_en_req;
                    pending_flag_reg <= 1'b0;
                end else if (pending_flag_reg) begin
                    active_reg       <= pending_reg;
                    pending_flag_reg <= 1'b0;
                end
            end else if (layer_en_wr) begin
                pending_reg      <= layer_en_req;
                pending_flag_reg <= 1'b1;
            end
        end
    end

    assign hsync           = hsync_reg;
    assign vsync           = vsync_reg;
    assign vgaRed          = rgb_reg[PIX_W-1 -: CH_W];
    assign vgaGreen        = rgb_reg[2*CH_W-1 -: CH_W];
    assign vgaBlue         = rgb_reg[CH_W-1:0];
    assign layer_en_active = active_reg;
    assign frame_cnt       = frame_cnt_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: queue-based reference model checked every cycle plus directed literal checks.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pix_en = 1'b0;
    logic             valid_in = 1'b0;
    logic             hsync_in = 1'b1;
    logic             vsync_in = 1'b1;
    logic [NL-1:0]    layer_valid = '0;
    logic [NL*12-1:0] layer_pixel = '0;
    logic [11:0]      bg_pixel = '0;
    logic [NL-1:0]    layer_en_req = '0;
    logic             layer_en_wr = 1'b0;
    logic             hsync, vsync;
    logic [CW-1:0]    vgaRed, vgaGreen, vgaBlue;
    logic [NL-1:0]    layer_en_active;
    logic [7:0]       frame_cnt;

    layer_compositor #(.NUM_LAYERS(NL), .CH_W(CW), .KEY_COLOR(12'h0F0)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .valid_in(valid_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_valid(layer_valid),
        .layer_pixel(layer_pixel), .bg_pixel(bg_pixel), .layer_en_req(layer_en_req),
        .layer_en_wr(layer_en_wr), .hsync(hsync), .vsync(vsync), .vgaRed(vgaRed),
        .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .layer_en_active(layer_en_active),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          valid;
        logic          hs;
        logic          vs;
        logic [NL-1:0] lv;
        logic [NL*12-1:0] lp;
        logic [11:0]   bg;
    } rec_t;

    rec_t          rec_q[$];
    logic [11:0]   m_rgb;
    logic          m_hs, m_vs;
    logic [NL-1:0] m_mask, m_pend;
    bit            m_have;
    logic [7:0]    m_cnt;
    logic          m_vs_prev;
    bit            model_ready = 0;

    function automatic logic [11:0] colour(input rec_t r, input logic [NL-1:0] m);
        if (!r.valid) return 12'h000;
        for (int i = NL - 1; i >= 0; i--) begin
            logic [11:0] p;
            p = r.lp[i*12 +: 12];
`ifdef COMPOSITOR_COLORKEY_EN
            if (r.lv[i] && m[i] && p != 12'h0F0) return p;
`else
            if (r.lv[i] && m[i]) return p;
`endif
        end
        return r.bg;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rec_q = {};
            rec_q.push_back('{valid: 1'b0, hs: 1'b1, vs: 1'b1, lv: '0, lp: '0, bg: '0});
            m_rgb = 12'h000; m_hs = 1'b1; m_vs = 1'b1;
            m_mask = '1; m_pend = '1; m_have = 0; m_cnt = 8'd0; m_vs_prev = 1'b1;
            model_ready = 1;
        end else if (model_ready) begin
            bit bnd;
            bnd = pix_en && m_vs_prev && !vsync_in;
            if (pix_en) begin
                rec_t r;
                r = rec_q.pop_front();
                m_rgb = colour(r, m_mask);
                m_hs = r.hs;
                m_vs = r.vs;
                rec_q.push_back('{valid: valid_in, hs: hsync_in, vs: vsync_in,
                                  lv: layer_valid, lp: layer_pixel, bg: bg_pixel});
                m_vs_prev = vsync_in;
            end
            if (layer_en_wr) begin
                m_pend = layer_en_req;
                m_have = 1;
            end
            if (bnd) begin
                m_cnt = m_cnt + 8'd1;
                if (m_have) begin
                    m_mask = m_pend;
                    m_have = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ready && !rst) begin
            chk("rgb", {20'd0, vgaRed, vgaGreen, vgaBlue}, {20'd0, m_rgb});
            chk("hsync", {31'd0, hsync}, {31'd0, m_hs});
            chk("vsync", {31'd0, vsync}, {31'd0, m_vs});
            chk("mask", {28'd0, layer_en_active}, {28'd0, m_mask});
            chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
        $display("check %-14s got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] out_rgb();
        return {vgaRed, vgaGreen, vgaBlue};
    endfunction

    task automatic set_layer(input int i, input logic [11:0] p);
        layer_pixel[i*12 +: 12] = p;
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic write_en(input logic [NL-1:0] m);
        layer_en_req = m;
        layer_en_wr  = 1'b1;
        tick();
        layer_en_wr  = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1; pix_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        lit("rst_rgb", {20'd0, out_rgb()}, 32'h000);
        lit("rst_hsync", {31'd0, hsync}, 32'h1);
        lit("rst_vsync", {31'd0, vsync}, 32'h1);
        lit("rst_mask", {28'd0, layer_en_active}, 32'hF);
        lit("rst_cnt", {24'd0, frame_cnt}, 32'h0);

        // Priority: L2 over L0, then background
        valid_in = 1'b1; layer_valid = 4'b0101;
        set_layer(0, 12'h00F); set_layer(2, 12'hF00); bg_pixel = 12'h111;
        tick(); tick();
        lit("prio_rgb", {20'd0, out_rgb()}, 32'hF00);
        lit("model_prio", {20'd0, m_rgb}, 32'hF00);
        layer_valid = 4'b0000;
        tick(); tick();
        lit("bg_rgb", {20'd0, out_rgb()}, 32'h111);

        // Blanking and hsync travel together
        valid_in = 1'b0; hsync_in = 1'b0;
        tick();
        lit("blank_lat1_rgb", {20'd0, out_rgb()}, 32'h111);
        lit("blank_lat1_hs", {31'd0, hsync}, 32'h1);
        tick();
        lit("blank_rgb", {20'd0, out_rgb()}, 32'h000);
        lit("blank_hs", {31'd0, hsync}, 32'h0);
        valid_in = 1'b1; hsync_in = 1'b1; layer_valid = 4'b0101;
        tick(); tick();
        lit("unblank_rgb", {20'd0, out_rgb()}, 32'hF00);

        // pix_en low freezes the pipeline
        pix_en = 1'b0; valid_in = 1'b0; hsync_in = 1'b0;
        tick(); tick(); tick();
        lit("freeze_rgb", {20'd0, out_rgb()}, 32'hF00);
        lit("freeze_hs", {31'd0, hsync}, 32'h1);
        pix_en = 1'b1; valid_in = 1'b1; hsync_in = 1'b1;
        tick(); tick();

        // Deferred enable: mask 1011 hides L2 only after the frame boundary
        write_en(4'b1011);
        tick(); tick(); tick();
        lit("defer_rgb", {20'd0, out_rgb()}, 32'hF00);
        lit("defer_mask", {28'd0, layer_en_active}, 32'hF);
        vsync_in = 1'b0;
        tick();
        lit("commit_mask", {28'd0, layer_en_active}, 32'hB);
        lit("commit_cnt", {24'd0, frame_cnt}, 32'h1);
        lit("commit_edge_rgb", {20'd0, out_rgb()}, 32'hF00);
        tick();
        lit("commit_rgb", {20'd0, out_rgb()}, 32'h00F);
        vsync_in = 1'b1;
        tick(); tick();

        // Two writes in one frame: last wins
        write_en(4'b0001);
        tick();
        write_en(4'b0010);
        tick();
        frame();
        lit("multi_mask", {28'd0, layer_en_active}, 32'h2);

        // Write on the boundary strobe commits at that edge
        layer_en_req = 4'b0100; layer_en_wr = 1'b1; vsync_in = 1'b0;
        tick();
        layer_en_wr = 1'b0;
        lit("simul_mask", {28'd0, layer_en_active}, 32'h4);
        vsync_in = 1'b1;
        tick();
        frame();
        lit("simul_hold", {28'd0, layer_en_active}, 32'h4);

        // Reset discards a pending write
        write_en(4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit("rst2_mask", {28'd0, layer_en_active}, 32'hF);
        lit("rst2_rgb", {20'd0, out_rgb()}, 32'h000);
        lit("rst2_hs", {31'd0, hsync}, 32'h1);
        lit("rst2_vs", {31'd0, vsync}, 32'h1);
        frame();
        lit("rst2_nocommit", {28'd0, layer_en_active}, 32'hF);

        // Frame counter wraps
        for (int f = 1; f < 255; f++) frame();
        lit("cnt_255", {24'd0, frame_cnt}, 32'hFF);
        frame();
        lit("cnt_wrap", {24'd0, frame_cnt}, 32'h0);

        // Colour key: L3 keyed green over L1
        layer_valid = 4'b1010; set_layer(3, 12'h0F0); set_layer(1, 12'hABC);
        tick(); tick();
`ifdef COMPOSITOR_COLORKEY_EN
        lit("key_rgb", {20'd0, out_rgb()}, 32'hABC);
`else
        lit("key_rgb", {20'd0, out_rgb()}, 32'h0F0);
`endif
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
